// File: rtl/input_fifo_stage.sv
// Input FIFO stage: DEPTH-entry first-word fall-through buffer between an
// upstream producer and a downstream register stage, with a sticky overflow flag.
module input_fifo_stage #(
    parameter int BITS  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BITS-1:0]          in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BITS-1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Handshakes depend only on registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A write offered while full is dropped and remembered until reset.
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_fifo_stage.sv
// Directed bench for input_fifo_stage: stimulus pushes expected words into a
// scoreboard queue, an independent monitor pops and compares on every output transfer.
module tb_input_fifo_stage;

    localparam int BITS  = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic [BITS-1:0]        in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [BITS-1:0]        out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    int ntests = 0;
    int nfail  = 0;

    logic [BITS-1:0] exp_q [$];
    int              mcount = 0;
    logic            mov    = 1'b0;

    input_fifo_stage #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_data, 32'hFFFF_FFFF);
                end else begin
                    check("out_data_order", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; checks state against the reference model at the negedge.
    task automatic cycle(input logic v, input logic [BITS-1:0] d, input logic r);
        logic push_ok, pop_ok;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        check("count",     32'(count),     32'(mcount));
        check("in_ready",  32'(in_ready),  32'(mcount != DEPTH));
        check("out_valid", 32'(out_valid), 32'(mcount != 0));
        check("overflow",  32'(overflow),  32'(mov));
        push_ok = v && (mcount != DEPTH);
        pop_ok  = r && (mcount != 0);
        if (push_ok) exp_q.push_back(d);
        if (v && !push_ok) mov = 1'b1;
        if (push_ok && !pop_ok) mcount++;
        if (pop_ok && !push_ok) mcount--;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill then drain; first push right after reset release.
        cycle(1'b1, 32'h11, 1'b0);
        cycle(1'b1, 32'h22, 1'b0);
        cycle(1'b1, 32'h33, 1'b0);
        cycle(1'b1, 32'h44, 1'b0);
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head",     out_data,      32'h11);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Continuous streaming through the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(i), 1'b1);
            check("wrap_count_le1", 32'(count <= 1), 32'd1);
        end
        cycle(1'b0, '0, 1'b1);
        check("wrap_overflow", 32'(overflow), 32'd0);
        cycle(1'b0, '0, 1'b0);

        // Simultaneous push and pop at occupancy 2.
        cycle(1'b1, 32'h1, 1'b0);
        cycle(1'b1, 32'h2, 1'b0);
        cycle(1'b1, 32'hA5A5_A5A5, 1'b1);
        check("simul_count", 32'(count), 32'd2);
        check("simul_head",  out_data,   32'h2);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Stall: head held while downstream is not ready.
        cycle(1'b1, 32'h77, 1'b0);
        cycle(1'b1, 32'h88, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0);
            check("stall_out_data", out_data, 32'h77);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Overflow: write while full is dropped and flag sticks.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b0);
        check("ovf_count", 32'(count),    32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset mid-stream with three entries.
        cycle(1'b1, 32'h31, 1'b0);
        cycle(1'b1, 32'h32, 1'b0);
        cycle(1'b1, 32'h33, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count",     32'(count),     32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_data",  out_data,       32'd0);
        check("mid_rst_overflow",  32'(overflow),  32'd0);
        exp_q.delete();
        mcount = 0;
        mov    = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h55, 1'b0);
        check("post_rst_head", out_data, 32'h55);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
